program_loader: RTL

Boot-time writer for the single-cycle RISC-V core's instruction store. Accepts a framed byte stream (e.g. from a UART receiver) over a valid/ready handshake, assembles little-endian 32-bit words, and writes them into the program memory's write port. Holds the core stalled while loading and validates the frame with a length header and an XOR checksum trailer. It is the writer side of the program memory that the core's fetch path reads.

---
 rtl/program_loader_pkg.sv | 42 ++++
 rtl/program_loader_byte_word_packer.sv | 52 +++++
 rtl/program_loader.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// Holds the loader state encoding, frame geometry and small helpers.
package program_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_CHECK  = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
    } loader_state_e;

    localparam int LEN_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;
    localparam int DEFAULT_DEPTH  = 64;

    // Word index must be able to hold the count N itself, not just N-1.
    function automatic int word_index_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic logic [7:0] checksum_next(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    function automatic logic is_ready_state(input loader_state_e s);
        case (s)
            ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CHECK: return 1'b1;
            default:                                  return 1'b0;
        endcase
    endfunction

    function automatic logic is_idle_state(input loader_state_e s);
        case (s)
            ST_IDLE, ST_DONE, ST_ERROR: return 1'b1;
            default:                    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/program_loader_byte_word_packer.sv
// Collects four stream bytes into a little-endian 32-bit word.
// word_valid_o fires combinationally with the 4th byte; word_o is valid with it.
module program_loader_byte_word_packer
    import program_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    localparam int CNT_W = $clog2(BYTES_PER_WORD);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES_PER_WORD - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    // Only the first three bytes need storage; the fourth is taken straight from the input.
    logic [23:0]      shift_q, shift_d;

    assign word_valid_o = byte_valid_i & (cnt_q == LAST_BYTE);
    assign word_o       = {byte_i, shift_q};

    // Byte counter and shift assembly next state.
    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        if (clear_i) begin
            cnt_d   = {CNT_W{1'b0}};
            shift_d = 24'h000000;
        end else if (byte_valid_i) begin
            cnt_d   = cnt_q + 1'b1;
            shift_d = {byte_i, shift_q[23:8]};
        end else begin
            cnt_d   = cnt_q;
            shift_d = shift_q;
        end
    end

    // Packer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= {CNT_W{1'b0}};
            shift_q <= 24'h000000;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Boot loader: parses a framed byte stream (length, payload, XOR trailer) and
// writes little-endian words into program memory while holding the core.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int PROGRAM_MEMORY_DEPTH = DEFAULT_DEPTH
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start_i,
    input  logic [7:0]  Byte_Data_i,
    input  logic        Byte_Valid_i,
    output logic        Byte_Ready_o,
    output logic        Mem_Write_o,
    output logic [31:0] Mem_Address_o,
    output logic [31:0] Mem_Data_o,
    output logic        Core_Hold_o,
    output logic        Busy_o,
    output logic        Done_o,
    output logic        Error_o
);

    localparam int WIDX_W = word_index_width(PROGRAM_MEMORY_DEPTH);
    localparam int LEN_W  = 8 * LEN_BYTES;
    localparam logic [LEN_W-1:0]  DEPTH_LEN = LEN_W'(PROGRAM_MEMORY_DEPTH);
    localparam logic [LEN_W-1:0]  LEN_ONE   = LEN_W'(1);
    localparam logic [WIDX_W-1:0] WIDX_ONE  = WIDX_W'(1);

    loader_state_e     state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [WIDX_W-1:0] widx_q, widx_d;
    logic [7:0]        csum_q, csum_d;
    logic              ready_q, ready_d;
    logic              write_q, write_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic              hold_q, hold_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic              xfer_s, start_s, pack_valid_s, word_valid_s;
    logic              last_word_s, len_zero_s, len_over_s, csum_ok_s;
    logic [31:0]       word_s;
    logic [LEN_W-1:0]  len_full_s;

    // ready_q mirrors the ready-state decode, so it doubles as the transfer qualifier.
    assign xfer_s       = Byte_Valid_i & ready_q;
    assign start_s      = Start_i & is_idle_state(state_q);
    assign pack_valid_s = xfer_s & (state_q == ST_DATA);
    assign len_full_s   = {Byte_Data_i, len_q[7:0]};
    assign len_zero_s   = (len_full_s == {LEN_W{1'b0}});
    assign len_over_s   = (len_full_s > DEPTH_LEN);
    assign last_word_s  = ((LEN_W'(widx_q) + LEN_ONE) == len_q);
    assign csum_ok_s    = (Byte_Data_i == csum_q);

    program_loader_byte_word_packer u_byte_word_packer (
        .clk          (clk),
        .rst_n        (reset),
        .clear_i      (start_s),
        .byte_valid_i (pack_valid_s),
        .byte_i       (Byte_Data_i),
        .word_o       (word_s),
        .word_valid_o (word_valid_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start_s) state_d = ST_LEN_LO;
                else         state_d = state_q;
            end
            ST_LEN_LO: begin
                if (xfer_s) state_d = ST_LEN_HI;
                else        state_d = state_q;
            end
            ST_LEN_HI: begin
                if (!xfer_s)         state_d = state_q;
                else if (len_zero_s) state_d = ST_CHECK;
                else if (len_over_s) state_d = ST_ERROR;
                else                 state_d = ST_DATA;
            end
            ST_DATA: begin
                if (word_valid_s && last_word_s) state_d = ST_CHECK;
                else                             state_d = state_q;
            end
            ST_CHECK: begin
                if (!xfer_s)        state_d = state_q;
                else if (csum_ok_s) state_d = ST_DONE;
                else                state_d = ST_ERROR;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs and datapath next values, all landing in registers.
    always_comb begin
        len_d   = len_q;
        widx_d  = widx_q;
        csum_d  = csum_q;
        write_d = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        hold_d  = hold_q;
        done_d  = done_q;
        error_d = error_q;
        ready_d = is_ready_state(state_d);
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start_s) begin
                    widx_d  = {WIDX_W{1'b0}};
                    csum_d  = 8'h00;
                    hold_d  = 1'b1;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                end else begin
                    hold_d  = hold_q;
                end
            end
            ST_LEN_LO: begin
                if (xfer_s) len_d = LEN_W'(Byte_Data_i);
                else        len_d = len_q;
            end
            ST_LEN_HI: begin
                if (xfer_s) begin
                    len_d   = len_full_s;
                    error_d = len_over_s ? 1'b1 : error_q;
                end else begin
                    len_d   = len_q;
                end
            end
            ST_DATA: begin
                if (pack_valid_s) csum_d = checksum_next(csum_q, Byte_Data_i);
                else              csum_d = csum_q;
                if (word_valid_s) begin
                    write_d = 1'b1;
                    addr_d  = {{(32 - WIDX_W - 2){1'b0}}, widx_q, 2'b00};
                    data_d  = word_s;
                    widx_d  = widx_q + WIDX_ONE;
                end else begin
                    write_d = 1'b0;
                end
            end
            ST_CHECK: begin
                if (xfer_s && csum_ok_s) begin
                    done_d = 1'b1;
                    hold_d = 1'b0;
                end else if (xfer_s) begin
                    error_d = 1'b1;
                end else begin
                    done_d = done_q;
                end
            end
            default: begin
                write_d = 1'b0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_q   <= {LEN_W{1'b0}};
            widx_q  <= {WIDX_W{1'b0}};
            csum_q  <= 8'h00;
            ready_q <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= 32'h0000_0000;
            data_q  <= 32'h0000_0000;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            len_q   <= len_d;
            widx_q  <= widx_d;
            csum_q  <= csum_d;
            ready_q <= ready_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    // Busy and ready cover exactly the same four states.
    assign Byte_Ready_o  = ready_q;
    assign Busy_o        = ready_q;
    assign Mem_Write_o   = write_q;
    assign Mem_Address_o = addr_q;
    assign Mem_Data_o    = data_q;
    assign Core_Hold_o   = hold_q;
    assign Done_o        = done_q;
    assign Error_o       = error_q;

endmodule
